// File: rtl/mem_lsu_pkg.sv
// Shared definitions for the memory-access stage: op codes, FSM states,
// pipeline constants and small op-classification helpers.
package mem_lsu_pkg;

    localparam int MEM_OP_W = 4;
    typedef logic [MEM_OP_W-1:0] mem_op_t;

    localparam mem_op_t MEM_OP_NONE = 4'd0;
    localparam mem_op_t MEM_OP_LB   = 4'd1;
    localparam mem_op_t MEM_OP_LH   = 4'd2;
    localparam mem_op_t MEM_OP_LW   = 4'd3;
    localparam mem_op_t MEM_OP_LBU  = 4'd4;
    localparam mem_op_t MEM_OP_LHU  = 4'd5;
    localparam mem_op_t MEM_OP_SB   = 4'd6;
    localparam mem_op_t MEM_OP_SH   = 4'd7;
    localparam mem_op_t MEM_OP_SW   = 4'd8;

    localparam logic [31:0] ZeroWord     = 32'h0000_0000;
    localparam logic        WriteEnable  = 1'b1;
    localparam logic        WriteDisable = 1'b0;
    localparam logic        Stop         = 1'b1;
    localparam logic        NoStop       = 1'b0;

    localparam int TIMEOUT_DEFAULT = 255;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } lsu_state_t;

    function automatic logic op_is_load(input mem_op_t op);
        return (op == MEM_OP_LB) || (op == MEM_OP_LH) || (op == MEM_OP_LW) ||
               (op == MEM_OP_LBU) || (op == MEM_OP_LHU);
    endfunction

    function automatic logic op_is_store(input mem_op_t op);
        return (op == MEM_OP_SB) || (op == MEM_OP_SH) || (op == MEM_OP_SW);
    endfunction

    // Half-word ops need addr[0] clear, word ops need addr[1:0] clear.
    function automatic logic op_misaligned(input mem_op_t op, input logic [1:0] lane);
        logic half, word;
        half = (op == MEM_OP_LH) || (op == MEM_OP_LHU) || (op == MEM_OP_SH);
        word = (op == MEM_OP_LW) || (op == MEM_OP_SW);
        return (half && lane[0]) || (word && (lane != 2'b00));
    endfunction

endpackage

// File: rtl/mem_lsu_if.sv
// Data-bus interface between the memory-access stage (master) and memory (slave).
interface mem_lsu_if;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_wdata_o;
    logic [3:0]  bus_sel_o;
    logic [31:0] bus_rdata_i;
    logic        bus_ack_i;

    modport master (
        output bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_sel_o,
        input  bus_rdata_i, bus_ack_i
    );

    modport slave (
        input  bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_sel_o,
        output bus_rdata_i, bus_ack_i
    );
endinterface

// File: rtl/mem_lsu_align.sv
// Byte-lane logic: byte enables, store-data replication, load extraction
// and sign/zero extension. Purely combinational.
module mem_lsu_align
    import mem_lsu_pkg::*;
(
    input  mem_op_t     i_op,
    input  logic [1:0]  i_lane,
    input  logic [31:0] i_sdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_sel,
    output logic [31:0] o_wdata,
    output logic [31:0] o_ldata
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_rdata[{i_lane, 3'b000} +: 8];
    assign w_half = i_lane[1] ? i_rdata[31:16] : i_rdata[15:0];

    // Select lanes by access size and build the aligned/extended views.
    always_comb begin
        o_sel   = 4'b1111;
        o_wdata = i_sdata;
        o_ldata = ZeroWord;
        case (i_op)
            MEM_OP_LB:  begin o_sel = 4'b0001 << i_lane;                 o_ldata = {{24{w_byte[7]}}, w_byte}; end
            MEM_OP_LBU: begin o_sel = 4'b0001 << i_lane;                 o_ldata = {24'h0, w_byte}; end
            MEM_OP_LH:  begin o_sel = i_lane[1] ? 4'b1100 : 4'b0011;     o_ldata = {{16{w_half[15]}}, w_half}; end
            MEM_OP_LHU: begin o_sel = i_lane[1] ? 4'b1100 : 4'b0011;     o_ldata = {16'h0, w_half}; end
            MEM_OP_LW:  begin o_sel = 4'b1111;                           o_ldata = i_rdata; end
            MEM_OP_SB:  begin o_sel = 4'b0001 << i_lane;                 o_wdata = {4{i_sdata[7:0]}}; end
            MEM_OP_SH:  begin o_sel = i_lane[1] ? 4'b1100 : 4'b0011;     o_wdata = {2{i_sdata[15:0]}}; end
            default:    begin o_sel = 4'b1111;                           o_wdata = i_sdata; end
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// Memory-access stage: passes ALU results through, runs a registered
// req/ack bus transaction for loads/stores and stalls the pipeline meanwhile.
// Optional MEM_BUS_TIMEOUT_EN aborts a transaction after TIMEOUT_CYCLES
// un-acked REQ cycles and pulses bus_err_o.
module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_wreg_i,
    input  logic [4:0]  mem_wreg_addr_i,
    input  logic [31:0] mem_wreg_data_i,
    input  logic [3:0]  mem_op_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_sdata_i,
    input  logic [4:0]  stalled_i,
    mem_lsu_if.master   bus,
    output logic        mem_wreg_o,
    output logic [4:0]  mem_wreg_addr_o,
    output logic [31:0] mem_wreg_data_o,
    output logic        stallreq_o,
    output logic        misalign_o,
    output logic        bus_err_o
);

    lsu_state_t  r_state, w_next;
    logic        r_req, r_we;
    logic [31:0] r_addr, r_wdata, r_ldata;
    logic [3:0]  r_sel;

    mem_op_t     w_op;
    logic        w_load, w_store, w_mis, w_go;
    logic        w_tmo, w_tmo_flag;
    logic [3:0]  w_sel;
    logic [31:0] w_wdata, w_ldata;
    logic        w_unused_stall;

    // Codes above SW behave exactly like NONE.
    assign w_op    = (mem_op_i > MEM_OP_SW) ? MEM_OP_NONE : mem_op_i;
    assign w_load  = op_is_load(w_op);
    assign w_store = op_is_store(w_op);
    assign w_mis   = op_misaligned(w_op, mem_addr_i[1:0]);
    assign w_go    = (w_load || w_store) && !w_mis;

    assign w_unused_stall = ^stalled_i[3:0];

    mem_lsu_align u_align (
        .i_op    (w_op),
        .i_lane  (mem_addr_i[1:0]),
        .i_sdata (mem_sdata_i),
        .i_rdata (bus.bus_rdata_i),
        .o_sel   (w_sel),
        .o_wdata (w_wdata),
        .o_ldata (w_ldata)
    );

`ifdef MEM_BUS_TIMEOUT_EN
    localparam logic [7:0] TMO_LIM = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] r_cnt;
    logic       r_tmo, r_err;

    assign w_tmo      = (r_state == REQ) && (r_cnt == TMO_LIM);
    assign w_tmo_flag = r_tmo;
    assign bus_err_o  = r_err;

    // Count un-acked REQ cycles; abort and flag once the limit is reached.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= 8'd0;
            r_tmo <= 1'b0;
            r_err <= 1'b0;
        end else begin
            r_err <= 1'b0;
            if (r_state == IDLE && w_go) begin
                r_cnt <= 8'd0;
                r_tmo <= 1'b0;
            end else if (r_state == REQ && !bus.bus_ack_i) begin
                if (w_tmo) begin
                    r_err <= 1'b1;
                    r_tmo <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + 8'd1;
                end
            end
        end
    end
`else
    logic [7:0] w_unused_tmo;
    assign w_unused_tmo = 8'(TIMEOUT_CYCLES);
    assign w_tmo        = 1'b0;
    assign w_tmo_flag   = 1'b0;
    assign bus_err_o    = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Next state, stall request and writeback steering.
    always_comb begin
        w_next          = r_state;
        stallreq_o      = 1'b0;
        mem_wreg_o      = w_mis ? WriteDisable : mem_wreg_i;
        mem_wreg_data_o = mem_wreg_data_i;
        case (r_state)
            IDLE: begin
                if (w_go) begin
                    stallreq_o = 1'b1;
                    w_next     = REQ;
                end
            end
            REQ: begin
                stallreq_o = 1'b1;
                if (bus.bus_ack_i || w_tmo) w_next = DONE;
            end
            DONE: begin
                if (w_load) begin
                    mem_wreg_data_o = r_ldata;
                    mem_wreg_o      = w_tmo_flag ? WriteDisable : mem_wreg_i;
                end else if (w_store) begin
                    mem_wreg_o = WriteDisable;
                end
                if (stalled_i[4] == NoStop) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Bus registers: load on issue, hold through REQ, drop req/we on ack or abort.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= ZeroWord;
            r_wdata <= ZeroWord;
            r_sel   <= 4'b0000;
            r_ldata <= ZeroWord;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_go) begin
                        r_req   <= 1'b1;
                        r_we    <= w_store;
                        r_addr  <= {mem_addr_i[31:2], 2'b00};
                        r_wdata <= w_wdata;
                        r_sel   <= w_sel;
                    end
                end
                REQ: begin
                    if (bus.bus_ack_i) begin
                        r_req <= 1'b0;
                        r_we  <= 1'b0;
                        if (w_load) r_ldata <= w_ldata;
                    end else if (w_tmo) begin
                        r_req   <= 1'b0;
                        r_we    <= 1'b0;
                        r_ldata <= ZeroWord;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.bus_req_o   = r_req;
    assign bus.bus_we_o    = r_we;
    assign bus.bus_addr_o  = r_addr;
    assign bus.bus_wdata_o = r_wdata;
    assign bus.bus_sel_o   = r_sel;

    assign mem_wreg_addr_o = mem_wreg_addr_i;
    assign misalign_o      = w_mis;

endmodule

// File: tb/tb_mem_lsu.sv
// Directed vector bench for mem_lsu: a table of single accesses plus
// hand-written sequences for long acks, writeback hold, reset and timeout.
module tb_mem_lsu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_wreg_i = 1'b0;
    logic [4:0]  mem_wreg_addr_i = 5'd0;
    logic [31:0] mem_wreg_data_i = 32'h0;
    logic [3:0]  mem_op_i = 4'd0;
    logic [31:0] mem_addr_i = 32'h0;
    logic [31:0] mem_sdata_i = 32'h0;
    logic [4:0]  stalled_i = 5'd0;
    logic        mem_wreg_o;
    logic [4:0]  mem_wreg_addr_o;
    logic [31:0] mem_wreg_data_o;
    logic        stallreq_o, misalign_o, bus_err_o;

    int n_vec = 0;
    int n_bad = 0;

    mem_lsu_if bus_if ();

    mem_lsu #(.TIMEOUT_CYCLES(4)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .mem_wreg_i      (mem_wreg_i),
        .mem_wreg_addr_i (mem_wreg_addr_i),
        .mem_wreg_data_i (mem_wreg_data_i),
        .mem_op_i        (mem_op_i),
        .mem_addr_i      (mem_addr_i),
        .mem_sdata_i     (mem_sdata_i),
        .stalled_i       (stalled_i),
        .bus             (bus_if),
        .mem_wreg_o      (mem_wreg_o),
        .mem_wreg_addr_o (mem_wreg_addr_o),
        .mem_wreg_data_o (mem_wreg_data_o),
        .stallreq_o      (stallreq_o),
        .misalign_o      (misalign_o),
        .bus_err_o       (bus_err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] addr;
        logic        wreg;
        logic [31:0] wdata;
        logic [31:0] sdata;
        logic [31:0] rdata;
        int          dly;
        logic        mis;
        logic [31:0] baddr;
        logic [3:0]  sel;
        logic [31:0] bwdata;
        logic        we;
        logic        ewreg;
        logic [31:0] edata;
    } vec_t;

    vec_t tbl [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] addr, input logic wreg,
                         input logic [31:0] wdata, input logic [31:0] sdata);
        mem_op_i        = op;
        mem_addr_i      = addr;
        mem_wreg_i      = wreg;
        mem_wreg_addr_i = 5'd9;
        mem_wreg_data_i = wdata;
        mem_sdata_i     = sdata;
    endtask

    // Called on a negedge with an access in IDLE; returns on the first negedge
    // with stallreq_o low. Acks in the (dly+1)-th REQ cycle.
    task automatic run_bus(input logic [31:0] rd, input int dly,
                           output int nstall, output int nreq, output bit stable, output bit hung,
                           output logic [31:0] a0, output logic [31:0] w0,
                           output logic [3:0] s0, output logic we0);
        nstall = 0; nreq = 0; stable = 1'b1; hung = 1'b1;
        a0 = 32'h0; w0 = 32'h0; s0 = 4'h0; we0 = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (!stallreq_o) begin
                hung = 1'b0;
                break;
            end
            nstall++;
            if (bus_if.bus_req_o) begin
                nreq++;
                if (nreq == 1) begin
                    a0 = bus_if.bus_addr_o; w0 = bus_if.bus_wdata_o;
                    s0 = bus_if.bus_sel_o;  we0 = bus_if.bus_we_o;
                end else if (a0 !== bus_if.bus_addr_o || w0 !== bus_if.bus_wdata_o ||
                             s0 !== bus_if.bus_sel_o || we0 !== bus_if.bus_we_o) begin
                    stable = 1'b0;
                end
                if (nreq == dly + 1) begin
                    bus_if.bus_ack_i   = 1'b1;
                    bus_if.bus_rdata_i = rd;
                end
            end
            @(negedge clk);
            bus_if.bus_ack_i   = 1'b0;
            bus_if.bus_rdata_i = 32'h5A5A_5A5A;
        end
    endtask

    initial begin
        int nstall, nreq;
        bit stable, hung;
        logic [31:0] a0, w0;
        logic [3:0] s0;
        logic we0;

        tbl[0]  = '{4'd0,  32'h0000_0005, 1'b1, 32'h1234_5678, 32'h0, 32'h0, 0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b1, 32'h1234_5678};
        tbl[1]  = '{4'd1,  32'h0000_1003, 1'b1, 32'h1111_0000, 32'h0, 32'h80FF_FFFF, 0, 1'b0, 32'h0000_1000, 4'b1000, 32'h0, 1'b0, 1'b1, 32'hFFFF_FF80};
        tbl[2]  = '{4'd4,  32'h0000_1003, 1'b1, 32'h1111_0000, 32'h0, 32'h80FF_FFFF, 0, 1'b0, 32'h0000_1000, 4'b1000, 32'h0, 1'b0, 1'b1, 32'h0000_0080};
        tbl[3]  = '{4'd7,  32'h0000_2002, 1'b1, 32'hAAAA_0000, 32'h0000_BEEF, 32'h0, 0, 1'b0, 32'h0000_2000, 4'b1100, 32'hBEEF_BEEF, 1'b1, 1'b0, 32'hAAAA_0000};
        tbl[4]  = '{4'd3,  32'h0000_3001, 1'b1, 32'h0, 32'h0, 32'h0, 0, 1'b1, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0};
        tbl[5]  = '{4'd2,  32'h0000_4002, 1'b1, 32'h0, 32'h0, 32'h8001_1234, 2, 1'b0, 32'h0000_4000, 4'b1100, 32'h0, 1'b0, 1'b1, 32'hFFFF_8001};
        tbl[6]  = '{4'd5,  32'h0000_4000, 1'b1, 32'h0, 32'h0, 32'h8001_F00D, 1, 1'b0, 32'h0000_4000, 4'b0011, 32'h0, 1'b0, 1'b1, 32'h0000_F00D};
        tbl[7]  = '{4'd6,  32'h0000_5001, 1'b1, 32'h0000_0055, 32'h1234_5678, 32'h0, 0, 1'b0, 32'h0000_5000, 4'b0010, 32'h7878_7878, 1'b1, 1'b0, 32'h0000_0055};
        tbl[8]  = '{4'd8,  32'h0000_6004, 1'b1, 32'h0000_0066, 32'hDEAD_BEEF, 32'h0, 3, 1'b0, 32'h0000_6004, 4'b1111, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0000_0066};
        tbl[9]  = '{4'd2,  32'h0000_7001, 1'b1, 32'h0, 32'h0, 32'h0, 0, 1'b1, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0};
        tbl[10] = '{4'd12, 32'h0000_0003, 1'b1, 32'h0BAD_F00D, 32'h0, 32'h0, 0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b1, 32'h0BAD_F00D};
        tbl[11] = '{4'd3,  32'h0000_8008, 1'b1, 32'h0, 32'h0, 32'hCAFE_BABE, 0, 1'b0, 32'h0000_8008, 4'b1111, 32'h0, 1'b0, 1'b1, 32'hCAFE_BABE};
        tbl[12] = '{4'd8,  32'h0000_9002, 1'b1, 32'h0, 32'h0, 32'h0, 0, 1'b1, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0};

        bus_if.bus_ack_i   = 1'b0;
        bus_if.bus_rdata_i = 32'h0;

        // Reset state
        #12;
        chk("rst bus_req", 32'(bus_if.bus_req_o), 32'h0);
        chk("rst bus_we", 32'(bus_if.bus_we_o), 32'h0);
        chk("rst bus_addr", bus_if.bus_addr_o, 32'h0);
        chk("rst bus_wdata", bus_if.bus_wdata_o, 32'h0);
        chk("rst bus_sel", 32'(bus_if.bus_sel_o), 32'h0);
        chk("rst bus_err", 32'(bus_err_o), 32'h0);
        chk("rst stallreq", 32'(stallreq_o), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table of single accesses
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            drive(tbl[i].op, tbl[i].addr, tbl[i].wreg, tbl[i].wdata, tbl[i].sdata);
            #1;
            chk($sformatf("v%0d misalign", i), 32'(misalign_o), 32'(tbl[i].mis));
            chk($sformatf("v%0d wreg_addr", i), 32'(mem_wreg_addr_o), 32'd9);
            if (tbl[i].mis || tbl[i].op == 4'd0 || tbl[i].op > 4'd8) begin
                chk($sformatf("v%0d wreg", i), 32'(mem_wreg_o), 32'(tbl[i].ewreg));
                chk($sformatf("v%0d stallreq", i), 32'(stallreq_o), 32'h0);
                if (!tbl[i].mis)
                    chk($sformatf("v%0d wdata", i), mem_wreg_data_o, tbl[i].edata);
                @(negedge clk);
                chk($sformatf("v%0d no req", i), 32'(bus_if.bus_req_o), 32'h0);
            end else begin
                run_bus(tbl[i].rdata, tbl[i].dly, nstall, nreq, stable, hung, a0, w0, s0, we0);
                chk($sformatf("v%0d timeout", i), 32'(hung), 32'h0);
                chk($sformatf("v%0d stall cycles", i), 32'(nstall), 32'(tbl[i].dly + 2));
                chk($sformatf("v%0d req cycles", i), 32'(nreq), 32'(tbl[i].dly + 1));
                chk($sformatf("v%0d stable", i), 32'(stable), 32'h1);
                chk($sformatf("v%0d bus_addr", i), a0, tbl[i].baddr);
                chk($sformatf("v%0d bus_sel", i), 32'(s0), 32'(tbl[i].sel));
                chk($sformatf("v%0d bus_wdata", i), w0, tbl[i].bwdata);
                chk($sformatf("v%0d bus_we", i), 32'(we0), 32'(tbl[i].we));
                chk($sformatf("v%0d done wreg", i), 32'(mem_wreg_o), 32'(tbl[i].ewreg));
                chk($sformatf("v%0d done data", i), mem_wreg_data_o, tbl[i].edata);
                chk($sformatf("v%0d done req", i), 32'(bus_if.bus_req_o), 32'h0);
            end
            drive(4'd0, 32'h0, 1'b0, 32'h0, 32'h0);
        end

        // Ack outside REQ is ignored
        @(negedge clk);
        bus_if.bus_ack_i = 1'b1;
        @(negedge clk);
        bus_if.bus_ack_i = 1'b0;
        #1;
        chk("stray ack req", 32'(bus_if.bus_req_o), 32'h0);
        chk("stray ack stall", 32'(stallreq_o), 32'h0);

        // Long ack plus writeback hold while mem_wb is stopped
        @(negedge clk);
        stalled_i = 5'b10000;
        drive(4'd3, 32'h0000_A000, 1'b1, 32'hEEEE_0000, 32'h0);
        #1;
        run_bus(32'h0123_4567, 5, nstall, nreq, stable, hung, a0, w0, s0, we0);
        chk("long timeout", 32'(hung), 32'h0);
        chk("long req cycles", 32'(nreq), 32'd6);
        chk("long stall cycles", 32'(nstall), 32'd7);
        chk("long stable", 32'(stable), 32'h1);
        chk("long addr", a0, 32'h0000_A000);
        chk("hold1 data", mem_wreg_data_o, 32'h0123_4567);
        chk("hold1 stall", 32'(stallreq_o), 32'h0);
        @(negedge clk);
        chk("hold2 data", mem_wreg_data_o, 32'h0123_4567);
        chk("hold2 wreg", 32'(mem_wreg_o), 32'h1);
        stalled_i = 5'b00000;
        @(negedge clk);
        // Back in IDLE: the still-present LW re-requests and data passes through
        chk("release stall", 32'(stallreq_o), 32'h1);
        chk("release data", mem_wreg_data_o, 32'hEEEE_0000);
        drive(4'd0, 32'h0, 1'b0, 32'h0, 32'h0);

        // Async reset in the middle of REQ
        @(negedge clk);
        drive(4'd3, 32'h0000_B000, 1'b1, 32'h0, 32'h0);
        @(negedge clk);
        chk("pre-reset req", 32'(bus_if.bus_req_o), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("reset req", 32'(bus_if.bus_req_o), 32'h0);
        chk("reset addr", bus_if.bus_addr_o, 32'h0);
        chk("reset idle stall", 32'(stallreq_o), 32'h1);
        drive(4'd0, 32'h0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

`ifdef MEM_BUS_TIMEOUT_EN
        // No ack at all: abort after 4 REQ cycles
        @(negedge clk);
        drive(4'd3, 32'h0000_C000, 1'b1, 32'h0, 32'h0);
        #1;
        run_bus(32'h0, 100, nstall, nreq, stable, hung, a0, w0, s0, we0);
        chk("tmo hung", 32'(hung), 32'h0);
        chk("tmo req cycles", 32'(nreq), 32'd4);
        chk("tmo err", 32'(bus_err_o), 32'h1);
        chk("tmo wreg", 32'(mem_wreg_o), 32'h0);
        chk("tmo data", mem_wreg_data_o, 32'h0);
        drive(4'd0, 32'h0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        chk("tmo err pulse", 32'(bus_err_o), 32'h0);
`else
        chk("err tied", 32'(bus_err_o), 32'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
